// File: rtl/riscv_pkg.sv
// Shared softcore definitions: instruction field ranges, opcodes, reset constants, fetch FSM encoding.
// Used by the fetch unit and the control decoder so both slice instructions identically.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // ADDI x0,x0,0

  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_MSB     = 11;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_MSB    = 19;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_MSB    = 24;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_MSB = 31;
  localparam int unsigned FUNCT7_LSB = 25;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FS_IDLE = 2'd0;
  localparam fetch_state_t FS_REQ  = 2'd1;
  localparam fetch_state_t FS_WAIT = 2'd2;
  localparam fetch_state_t FS_HOLD = 2'd3;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read, result held until decode takes it; 3-cycle fetch-to-fetch minimum.
// Decode backpressure (instr_ready_i low) parks the unit in HOLD with no new request; redirect squashes wrong-path data.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        misalign_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         kill_q, kill_d;
  logic         misalign_q, misalign_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    kill_d     = kill_q;
    misalign_d = redirect_i & (redirect_pc_i[1:0] != 2'b00);

    case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        state_d = FS_WAIT;
        if (redirect_i) kill_d = 1'b1;
      end
      FS_WAIT: begin
        if (imem_rvalid_i) begin
          // A redirect arriving with the response kills it just like a pending kill does.
          if (kill_q || redirect_i) begin
            kill_d  = 1'b0;
            state_d = FS_REQ;
          end else begin
            instr_d  = imem_rdata_i;
            pc_out_d = pc_q;
            state_d  = FS_HOLD;
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (redirect_i) begin
          state_d = FS_REQ;
        end else if (instr_ready_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = FS_REQ;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    if (redirect_i) pc_d = {redirect_pc_i[31:2], 2'b00};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= RESET_PC;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o    = (state_q == FS_REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == FS_HOLD) & ~redirect_i;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign misalign_o    = misalign_q;

  assign opcode_o = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct3_o = instr_q[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_o = instr_q[FUNCT7_MSB:FUNCT7_LSB];
  assign rd_o     = instr_q[RD_MSB:RD_LSB];
  assign rs1_o    = instr_q[RS1_MSB:RS1_LSB];
  assign rs2_o    = instr_q[RS2_MSB:RS2_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_ready_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_ready_i(instr_ready_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .pc_o(pc_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n_i = 1'b0;
    tick();
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr got %h want 00000013", instr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b want 0", misalign_o); end
    checks++; if (opcode_o !== 7'h13 || rd_o !== 5'd0 || rs1_o !== 5'd0) begin
      errors++; $display("FAIL rst_fields got op=%h rd=%0d rs1=%0d want op=13 rd=0 rs1=0", opcode_o, rd_o, rs1_o);
    end
    rst_n_i = 1'b1;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_basic_fetch();
    tick();
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL wait_idle got req=%b valid=%b want 0 0", imem_req_o, instr_valid_o);
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    tick();
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      errors++; $display("FAIL hold_valid got valid=%b pc=%h want 1 0", instr_valid_o, pc_o);
    end
    checks++; if (opcode_o !== 7'h13 || rd_o !== 5'd1 || funct3_o !== 3'd0 || rs1_o !== 5'd0 || rs2_o !== 5'd5 || funct7_o !== 7'd0) begin
      errors++; $display("FAIL fields got op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h want 13 1 0 0 5 00",
                         opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o);
    end
    tick();
    instr_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      errors++; $display("FAIL next_req got req=%b addr=%h want 1 00000004", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_hold_stall();
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0113;
    tick();
    imem_rvalid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || instr_o !== 32'h00A0_0113 || pc_o !== 32'h4 || rd_o !== 5'd2) begin
        errors++; $display("FAIL stall_%0d got valid=%b req=%b instr=%h pc=%h rd=%0d want 1 0 00a00113 00000004 2",
                           i, instr_valid_o, imem_req_o, instr_o, pc_o, rd_o);
      end
      tick();
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
      errors++; $display("FAIL stall_release got req=%b addr=%h want 1 00000008", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_wait();
    instr_ready_i = 1'b1;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL rw_wait got req=%b mis=%b want 0 0", imem_req_o, misalign_o);
    end
    tick();
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rw_stale_valid got %b want 0", instr_valid_o); end
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h00A0_0113) begin
      errors++; $display("FAIL rw_drop got valid=%b instr=%h want 0 00a00113", instr_valid_o, instr_o);
    end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL rw_target got req=%b addr=%h want 1 00000100", imem_req_o, imem_addr_o);
    end
    instr_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_redirect_rvalid_same();
    redirect_i = 1'b1; redirect_pc_i = 32'h180;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    redirect_i = 1'b0; imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h180) begin
      errors++; $display("FAIL rs_target got req=%b addr=%h want 1 00000180", imem_req_o, imem_addr_o);
    end
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h00A0_0113) begin
      errors++; $display("FAIL rs_drop got valid=%b instr=%h want 0 00a00113", instr_valid_o, instr_o);
    end
    tick();
  endtask

  task automatic test_redirect_hold();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0030_0193;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h180 || rd_o !== 5'd3) begin
      errors++; $display("FAIL rh_hold got valid=%b pc=%h rd=%0d want 1 00000180 3", instr_valid_o, pc_o, rd_o);
    end
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rh_gate got %b want 0", instr_valid_o); end
    tick();
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300 || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL rh_target got req=%b addr=%h valid=%b want 1 00000300 0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    tick();
  endtask

  task automatic test_misalign();
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    #1;
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_early got %b want 0", misalign_o); end
    tick();
    redirect_i = 1'b0;
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b want 1", misalign_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misalign_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      errors++; $display("FAIL mis_target got req=%b addr=%h want 1 00000200", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC || instr_o !== 32'h0030_0193) begin
      errors++; $display("FAIL wrap_req got req=%b addr=%h instr=%h want 1 fffffffc 00300193", imem_req_o, imem_addr_o, instr_o);
    end
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_hold got valid=%b pc=%h want 1 fffffffc", instr_valid_o, pc_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap_next got req=%b addr=%h want 1 00000000", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    rst_n_i = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0000_0013 || pc_o !== 32'h0 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL rm_reset got req=%b valid=%b instr=%h pc=%h mis=%b want 0 0 00000013 0 0",
                         imem_req_o, instr_valid_o, instr_o, pc_o, misalign_o);
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    rst_n_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || instr_o !== 32'h0000_0013) begin
      errors++; $display("FAIL rm_idle_rvalid got req=%b addr=%h instr=%h want 1 0 00000013", imem_req_o, imem_addr_o, instr_o);
    end
    imem_rvalid_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL rm_req_rvalid got valid=%b req=%b want 0 0", instr_valid_o, imem_req_o);
    end
    tick();
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h0000_0013) begin
      errors++; $display("FAIL rm_still_wait got valid=%b instr=%h want 0 00000013", instr_valid_o, instr_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_rvalid_same();
    test_redirect_hold();
    test_misalign();
    test_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the softcore. Owns the program counter and issues one word read at a time to instruction memory. Holds the returned instruction in an instruction register and presents it, already split into fields, to the decode/control stage through a valid/ready handshake. Supports PC redirect from execute (jumps, taken branches) with wrong-path squash.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
NOP_INSTR, 32'h0000_0013, value of instr_o while no valid instruction is held (ADDI x0,x0,0).

Ports:
clk_i  input  1  system clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
imem_req_o  output  1  read request to instruction memory, one cycle per fetch
imem_addr_o  output  32  fetch address; bits [1:0] always 0
imem_rvalid_i  input  1  single-cycle pulse: imem_rdata_i valid
imem_rdata_i  input  32  instruction word
redirect_i  input  1  load new PC and squash in-flight/held instruction
redirect_pc_i  input  32  redirect target
instr_ready_i  input  1  decode stage accepts instruction this cycle
instr_valid_o  output  1  instruction register holds a valid instruction
instr_o  output  32  held instruction word
pc_o  output  32  address of held instruction
opcode_o  output  7  instr_o[6:0]
funct3_o  output  3  instr_o[14:12]
funct7_o  output  7  instr_o[31:25]
rd_o  output  5  instr_o[11:7]
rs1_o  output  5  instr_o[19:15]
rs2_o  output  5  instr_o[24:20]
misalign_o  output  1  one-cycle pulse: redirect_pc_i[1:0] != 0

Behaviour:
- Reset (async, rst_n_i low): state IDLE; pc register = RESET_PC; instr register = NOP_INSTR; pc_o = RESET_PC; kill flag = 0; imem_req_o = 0; instr_valid_o = 0; misalign_o = 0. Field outputs decode NOP_INSTR.
- Field outputs are purely combinational slices of the instr register.
- Memory protocol: a fetch is issued in any cycle with imem_req_o=1. Exactly one fetch outstanding. Response arrives as a single imem_rvalid_i pulse, at least 1 cycle after the request. rvalid in any state other than WAIT is ignored.
- FSM:
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc -> WAIT unconditionally.
  - WAIT: on rvalid with kill=0, capture rdata into instr reg and pc into pc_o -> HOLD. On rvalid with kill=1, drop data, clear kill -> REQ.
  - HOLD: instr_valid_o=1. On instr_ready_i & !redirect_i, pc <= pc+4 (wraps modulo 2^32) -> REQ.
- instr_valid_o = (state==HOLD) & !redirect_i (combinational gate); a held wrong-path instruction is never handed over.
- Redirect, in any state: pc <= {redirect_pc_i[31:2],2'b00}; misalign_o pulses next cycle if redirect_pc_i[1:0]!=0.
  - IDLE/HOLD: next state REQ; instr reg unchanged.
  - REQ (request issued the same cycle): -> WAIT with kill=1.
  - WAIT, no rvalid: stay WAIT, kill=1.
  - WAIT with rvalid in the same cycle: drop data, kill=0 -> REQ.
- Back-to-back redirects: last one wins; kill stays set until the outstanding response drains.
- Peak throughput: 1 instruction per 3 cycles (REQ, WAIT with 1-cycle memory, HOLD with ready high).
- Reset mid-fetch: everything returns to reset values. A late rvalid after reset lands in IDLE or REQ and is ignored.

Decomposition:
- Shared package riscv_pkg: instruction field bit ranges, NOP_INSTR, RESET_PC default, fetch FSM state enum (IDLE, REQ, WAIT, HOLD).
- Opcode constants in the package are shared with the control decoder.
- No sub-module; field slicing is wiring only.

Test Plan:
- Reset release, memory returns 32'h00500093 one cycle after each req -> req at 0x0 on cycle 2; instr_valid_o with pc_o=0, opcode_o=7'h13, rd_o=1; with ready held, next req at 0x4.
- instr_ready_i held low 10 cycles in HOLD -> instr_valid_o stays 1, no new imem_req_o, outputs stable; ready high -> req at pc+4 next cycle.
- redirect_i to 0x100 while in WAIT, rvalid 3 cycles later with 32'hDEADBEEF -> data dropped, instr_valid_o never 1 for it, next req at 0x100.
- redirect_i and imem_rvalid_i in the same WAIT cycle -> data dropped, req at target next cycle.
- redirect_i in HOLD with instr_ready_i high -> instr_valid_o low that cycle, next req at target.
- redirect_pc_i=0x203 -> misalign_o pulses one cycle, req at 0x200.
- pc=0xFFFFFFFC accepted -> next req at 0x00000000.
- rst_n_i asserted during WAIT -> all outputs at reset values immediately; stale rvalid afterwards ignored.
